// File: rtl/seven_segment_pkg.sv
// Shared seven-segment glyph constants, pattern type and reader FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seven_segment_pkg;

  // Active-low segment pattern: bit0 = a ... bit6 = g, 0 = segment lit.
  typedef logic [6:0] segment_t;

  localparam segment_t SEG_0     = 7'h40;
  localparam segment_t SEG_1     = 7'h79;
  localparam segment_t SEG_2     = 7'h24;
  localparam segment_t SEG_3     = 7'h30;
  localparam segment_t SEG_4     = 7'h19;
  localparam segment_t SEG_5     = 7'h12;
  localparam segment_t SEG_6     = 7'h02;
  localparam segment_t SEG_7     = 7'h78;
  localparam segment_t SEG_8     = 7'h00;
  localparam segment_t SEG_9     = 7'h10;
  localparam segment_t SEG_A     = 7'h08;
  localparam segment_t SEG_B     = 7'h03;
  localparam segment_t SEG_C     = 7'h46;
  localparam segment_t SEG_D     = 7'h21;
  localparam segment_t SEG_E     = 7'h06;
  localparam segment_t SEG_F     = 7'h0E;
  localparam segment_t SEG_BLANK = 7'h7F;

  typedef enum logic {
    S_SETTLE,
    S_HOLD
  } reader_state_t;

endpackage

// File: rtl/segment_to_binary.sv
// Combinational inverse of the seven-segment decoder: glyph pattern to hex value.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows input continuously.
module segment_to_binary
  import seven_segment_pkg::*;
(
  input  segment_t    pattern_i,
  output logic [3:0]  value_o,
  output logic        legal_o,
  output logic        blank_o
);

  // Table lookup; anything outside the 16 glyphs is illegal, blank flagged separately.
  always_comb begin
    value_o = 4'h0;
    legal_o = 1'b1;
    blank_o = 1'b0;
    case (pattern_i)
      SEG_0:     value_o = 4'h0;
      SEG_1:     value_o = 4'h1;
      SEG_2:     value_o = 4'h2;
      SEG_3:     value_o = 4'h3;
      SEG_4:     value_o = 4'h4;
      SEG_5:     value_o = 4'h5;
      SEG_6:     value_o = 4'h6;
      SEG_7:     value_o = 4'h7;
      SEG_8:     value_o = 4'h8;
      SEG_9:     value_o = 4'h9;
      SEG_A:     value_o = 4'hA;
      SEG_B:     value_o = 4'hB;
      SEG_C:     value_o = 4'hC;
      SEG_D:     value_o = 4'hD;
      SEG_E:     value_o = 4'hE;
      SEG_F:     value_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_reader.sv
// Debounces an active-low segment pattern and reports its hex value once per new glyph.
// Latency: STABLE_CYCLES+1 edges from first stable sample to the o_valid pulse.
// Backpressure: none; o_valid is a single-cycle pulse that must be consumed when seen.
module segment_reader
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_display,
  output logic [3:0] o_binary_number,
  output logic       o_valid,
  output logic       o_error
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

  segment_t      sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  reader_state_t state_q, state_d;
  segment_t      last_q, last_d;
  logic          last_vld_q, last_vld_d;
  logic          valid_q, valid_d;
  logic [3:0]    num_q, num_d;
  logic          err_q, err_d;

  logic          changed;
  logic          evaluate;
  logic [3:0]    lut_value;
  logic          lut_legal;
  logic          lut_blank;

  segment_to_binary u_lut (
    .pattern_i (sample_q),
    .value_o   (lut_value),
    .legal_o   (lut_legal),
    .blank_o   (lut_blank)
  );

  assign changed = (i_display != sample_q);

  // Stability counter: restart at 1 on a new value, otherwise count up and saturate.
  always_comb begin
    sample_d = i_display;
    cnt_d    = cnt_q;
    if (changed) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Settle/hold FSM. A pattern that changes on the very edge it is evaluated
  // goes straight back to settling so the new value still gets its own turn.
  always_comb begin
    state_d  = state_q;
    evaluate = 1'b0;
    case (state_q)
      S_SETTLE: begin
        if (cnt_q == CNT_FULL) begin
          evaluate = 1'b1;
          state_d  = changed ? S_SETTLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (changed) state_d = S_SETTLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

  // Report decision: blank re-arms, duplicates are dropped, everything else pulses.
  always_comb begin
    valid_d    = 1'b0;
    num_d      = num_q;
    err_d      = err_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (evaluate) begin
      if (lut_blank) begin
        last_vld_d = 1'b0;
      end else if (!(last_vld_q && (sample_q == last_q))) begin
        valid_d    = 1'b1;
        num_d      = lut_legal ? lut_value : 4'h0;
        err_d      = ~lut_legal;
        last_d     = sample_q;
        last_vld_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_q   <= SEG_BLANK;
      cnt_q      <= '0;
      state_q    <= S_SETTLE;
      last_q     <= SEG_BLANK;
      last_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      num_q      <= 4'h0;
      err_q      <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      valid_q    <= valid_d;
      num_q      <= num_d;
      err_q      <= err_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_binary_number = num_q;
  assign o_error         = err_q;

endmodule

// File: tb/tb_segment_reader.sv
// Randomized and directed bench for segment_reader against a run-length reference model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_segment_reader;

  localparam int STABLE = 4;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [6:0] i_display = 7'h7F;
  logic [3:0] o_binary_number;
  logic       o_valid;
  logic       o_error;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference glyph table: index is the hex value.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: current run of identical samples and report history.
  logic [6:0] run_pat = 7'h7F;
  int         run_len = 0;
  logic [6:0] last_pat = 7'h7F;
  logic       last_set = 1'b0;
  logic       pend_vld = 1'b0;
  logic [3:0] pend_num = 4'h0;
  logic       pend_err = 1'b0;
  logic       exp_vld = 1'b0;
  logic [3:0] exp_num = 4'h0;
  logic       exp_err = 1'b0;

  segment_reader #(.STABLE_CYCLES(STABLE)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_display       (i_display),
    .o_binary_number (o_binary_number),
    .o_valid         (o_valid),
    .o_error         (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decide what a run that just reached STABLE samples should report.
  task automatic model_eval(input logic [6:0] pat);
    int idx;
    idx = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == pat) idx = i;
    if (pat == 7'h7F) begin
      last_set = 1'b0;
    end else if (!(last_set && pat == last_pat)) begin
      pend_vld = 1'b1;
      pend_num = (idx >= 0) ? 4'(idx) : 4'h0;
      pend_err = (idx < 0);
      last_pat = pat;
      last_set = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance model, compare outputs after the edge.
  task automatic step(input logic [6:0] disp, input logic rst);
    i_display = disp;
    i_reset   = rst;
    @(posedge i_clk);
    if (rst) begin
      exp_vld  = 1'b0;
      exp_num  = 4'h0;
      exp_err  = 1'b0;
      pend_vld = 1'b0;
      run_len  = 0;
      last_set = 1'b0;
    end else begin
      exp_vld = pend_vld;
      if (pend_vld) begin
        exp_num = pend_num;
        exp_err = pend_err;
      end
      pend_vld = 1'b0;
      if (run_len != 0 && disp == run_pat) begin
        run_len++;
      end else begin
        run_pat = disp;
        run_len = 1;
      end
      if (run_len == STABLE) model_eval(run_pat);
    end
    #1;
    check("valid", 32'(o_valid), 32'(exp_vld));
    check("value", 32'(o_binary_number), 32'(exp_num));
    check("error", 32'(o_error), 32'(exp_err));
    if (o_valid) pulses++;
  endtask

  task automatic hold(input logic [6:0] disp, input int n);
    for (int k = 0; k < n; k++) step(disp, 1'b0);
  endtask

  initial begin
    logic [6:0] cur;
    int         kind;
    int         len;

    step(7'h7F, 1'b1);
    step(7'h7F, 1'b1);

    // Single glyph held: exactly one report of 2.
    pulses = 0;
    hold(7'h24, 10);
    check("hold_pulses", 32'(pulses), 32'd1);

    // Full sweep of legal glyphs.
    pulses = 0;
    for (int i = 0; i < 16; i++) hold(glyph[i], 6);
    check("sweep_pulses", 32'(pulses), 32'd16);

    // Blank between identical glyphs re-arms the report.
    pulses = 0;
    hold(7'h40, 6);
    hold(7'h7F, 6);
    hold(7'h40, 6);
    check("blank_rearm_pulses", 32'(pulses), 32'd2);

    // Short glitch is ignored and the returning glyph is a duplicate.
    hold(7'h7F, 6);
    pulses = 0;
    hold(7'h40, 6);
    hold(7'h79, 2);
    hold(7'h40, 6);
    check("glitch_pulses", 32'(pulses), 32'd1);

    // Illegal pattern then a legal one.
    pulses = 0;
    hold(7'h7E, 6);
    hold(7'h08, 6);
    check("illegal_pulses", 32'(pulses), 32'd2);

    // Reset mid-settle abandons progress; same pattern reports afterwards.
    pulses = 0;
    hold(7'h30, 3);
    step(7'h30, 1'b1);
    hold(7'h30, 7);
    check("reset_mid_pulses", 32'(pulses), 32'd1);

    // Alternation faster than the debounce window never reports.
    pulses = 0;
    for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 7'h19 : 7'h12, 3);
    check("alternate_pulses", 32'(pulses), 32'd0);

    // Random runs of glyphs, blanks, illegal patterns and short resets.
    cur = 7'h7F;
    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 11);
      len  = $urandom_range(1, 7);
      if (kind <= 6)       cur = glyph[$urandom_range(0, 15)];
      else if (kind == 7)  cur = 7'h7F;
      else if (kind <= 9)  cur = 7'($urandom_range(0, 127));
      if (kind == 11) step(cur, 1'b1);
      else            hold(cur, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
